video_frame_ctrl: RTL and testbench

- CPU-facing control block for the RGB compositor and tilemap layers.
- Decodes CPU IO writes into display control registers (scanlines, layer enables, screen enable, scroll).
- Double-buffers each write and commits it on the vertical-sync edge, so no layer or scroll change tears mid-frame.
- Generates the CPU wait-for-vblank stall (cpuwait) and a free-running frame counter.

---
 rtl/video_frame_ctrl.sv | 141 ++++++++++++++
 tb/tb_video_frame_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/video_frame_ctrl.sv
// CPU IO register block for the compositor: decodes display control writes into
// shadow registers, commits them on the vsync falling edge, and drives the vblank stall.
module video_frame_ctrl #(
  parameter logic [7:0] IO_BASE = 8'h20,
  parameter int         FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_in,
  input  logic [15:0]        io_address_in,
  input  logic [7:0]         io_data_in,
  input  logic               vga_v_sync,
  output logic               show_scan_lines,
  output logic               background_enable,
  output logic               foreground_enable,
  output logic               spr_enable,
  output logic               spr2_enable,
  output logic               screen_enable,
  output logic [9:0]         scroll_x,
  output logic [8:0]         scroll_y,
  output logic               cpuwait,
  output logic [FRAME_W-1:0] frame_count,
  output logic               pending
);

  typedef struct packed {
    logic       screen;
    logic       spr2;
    logic       spr;
    logic       fg;
    logic       bg;
    logic       scan;
    logic [9:0] sx;
    logic [8:0] sy;
  } disp_t;

  localparam disp_t DISP_RST = '{screen: 1'b1, spr2: 1'b1, spr: 1'b1, fg: 1'b1,
                                 bg: 1'b1, scan: 1'b0, sx: 10'd0, sy: 9'd0};

  // Merge one register-byte write into a display set; other offsets leave it untouched.
  function automatic disp_t apply_wr(input disp_t base, input logic [7:0] off,
                                     input logic [7:0] d);
    disp_t r;
    r = base;
    case (off)
      8'd0: begin
        r.scan   = d[0];
        r.bg     = d[1];
        r.fg     = d[2];
        r.spr    = d[3];
        r.spr2   = d[4];
        r.screen = d[7];
      end
      8'd1: r.sx[7:0] = d;
      8'd2: begin
        r.sx[9:8] = d[1:0];
        r.sy[8]   = d[4];
      end
      8'd3: r.sy[7:0] = d;
      default: r = base;
    endcase
    return r;
  endfunction

  disp_t              shadow_r, active_r;
  disp_t              shadow_nxt_s, active_nxt_s, commit_base_s;
  logic               ack_r, vs_prev_r, imm_r, pend_r, wait_r;
  logic               pend_nxt_s, wait_nxt_s, imm_nxt_s;
  logic [FRAME_W-1:0] fc_r;
  logic [7:0]         off_s;
  logic               wr_s, event_s, shadow_wr_s, wait_wr_s, mode_wr_s;
  logic               unused_addr_s;

  assign unused_addr_s = ^io_address_in[15:8];

  // Write decode, commit detection and next-state selection.
  always_comb begin
    off_s         = io_address_in[7:0] - IO_BASE;
    wr_s          = ~io_in & ~ack_r;
    event_s       = vs_prev_r & ~vga_v_sync;
    shadow_wr_s   = wr_s & (off_s < 8'd4);
    wait_wr_s     = wr_s & (off_s == 8'd4);
    mode_wr_s     = wr_s & (off_s == 8'd5);
    commit_base_s = event_s ? shadow_r : active_r;

    if (shadow_wr_s) shadow_nxt_s = apply_wr(shadow_r, off_s, io_data_in);
    else             shadow_nxt_s = shadow_r;

    // Immediate writes land on top of whatever this edge commits.
    if (shadow_wr_s && imm_r) active_nxt_s = apply_wr(commit_base_s, off_s, io_data_in);
    else                      active_nxt_s = commit_base_s;

    if (shadow_wr_s && !imm_r) pend_nxt_s = 1'b1;
    else if (event_s)          pend_nxt_s = 1'b0;
    else                       pend_nxt_s = pend_r;

    // A WAITVB write on a commit edge arms for the following frame.
    if (wait_wr_s && !wait_r) wait_nxt_s = 1'b1;
    else if (event_s)         wait_nxt_s = 1'b0;
    else                      wait_nxt_s = wait_r;

    if (mode_wr_s) imm_nxt_s = io_data_in[0];
    else           imm_nxt_s = imm_r;
  end

  // State registers; the ack flag tracks io_in even through reset so a held strobe is not replayed.
  always_ff @(posedge clk) begin
    ack_r <= ~io_in;
    if (reset) begin
      shadow_r  <= DISP_RST;
      active_r  <= DISP_RST;
      vs_prev_r <= 1'b1;
      imm_r     <= 1'b0;
      pend_r    <= 1'b0;
      wait_r    <= 1'b0;
      fc_r      <= '0;
    end else begin
      shadow_r  <= shadow_nxt_s;
      active_r  <= active_nxt_s;
      vs_prev_r <= vga_v_sync;
      imm_r     <= imm_nxt_s;
      pend_r    <= pend_nxt_s;
      wait_r    <= wait_nxt_s;
      if (event_s) fc_r <= fc_r + FRAME_W'(1);
      else         fc_r <= fc_r;
    end
  end

  assign show_scan_lines   = active_r.scan;
  assign background_enable = active_r.bg;
  assign foreground_enable = active_r.fg;
  assign spr_enable        = active_r.spr;
  assign spr2_enable       = active_r.spr2;
  assign screen_enable     = active_r.screen;
  assign scroll_x          = active_r.sx;
  assign scroll_y          = active_r.sy;
  assign cpuwait           = wait_r;
  assign frame_count       = fc_r;
  assign pending           = pend_r;

endmodule

// File: tb/tb_video_frame_ctrl.sv
// Bench for video_frame_ctrl: directed vector table, a frame-counter wrap sequence and
// random traffic, all compared each cycle against a byte-level register model.
module tb_video_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset, io_in, vga_v_sync;
  logic [15:0] io_address_in;
  logic [7:0]  io_data_in;
  logic        show_scan_lines, background_enable, foreground_enable;
  logic        spr_enable, spr2_enable, screen_enable, cpuwait, pending;
  logic [9:0]  scroll_x;
  logic [8:0]  scroll_y;
  logic [7:0]  frame_count;
  logic [5:0]  en_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  video_frame_ctrl #(.IO_BASE(8'h20), .FRAME_W(8)) dut (
    .clk(clk), .reset(reset), .io_in(io_in), .io_address_in(io_address_in),
    .io_data_in(io_data_in), .vga_v_sync(vga_v_sync),
    .show_scan_lines(show_scan_lines), .background_enable(background_enable),
    .foreground_enable(foreground_enable), .spr_enable(spr_enable),
    .spr2_enable(spr2_enable), .screen_enable(screen_enable),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .cpuwait(cpuwait),
    .frame_count(frame_count), .pending(pending)
  );

  assign en_s = {screen_enable, spr2_enable, spr_enable, foreground_enable,
                 background_enable, show_scan_lines};

  // Register-file model: four raw register bytes per set, decoded into outputs on compare.
  logic [7:0] m_sh [4];
  logic [7:0] m_ac [4];
  logic [7:0] m_fc;
  bit         m_pend, m_imm, m_wait, m_ack, m_vprev;

  typedef struct {
    bit         rst;
    bit         io;
    logic [7:0] addr;
    logic [7:0] data;
    bit         vs;
    logic [5:0] en;
    logic [9:0] sx;
    logic [8:0] sy;
    bit         w;
    bit         p;
    logic [7:0] fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, io, input logic [7:0] addr, data, input bit vs,
                              input logic [5:0] en, input logic [9:0] sx,
                              input logic [8:0] sy, input bit w, p, input logic [7:0] fc);
    vec_t v;
    v.rst = rst; v.io = io; v.addr = addr; v.data = data; v.vs = vs;
    v.en = en; v.sx = sx; v.sy = sy; v.w = w; v.p = p; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int off;
    bit ev, acc;
    if (reset) begin
      m_sh   = '{8'h9E, 8'h00, 8'h00, 8'h00};
      m_ac   = '{8'h9E, 8'h00, 8'h00, 8'h00};
      m_pend = 1'b0; m_imm = 1'b0; m_wait = 1'b0; m_fc = 8'd0; m_vprev = 1'b1;
    end else begin
      ev  = m_vprev && !vga_v_sync;
      acc = !io_in && !m_ack;
      off = int'(io_address_in[7:0]) - 32;
      if (ev) begin
        m_ac   = m_sh;
        m_pend = 1'b0;
        m_fc   = m_fc + 8'd1;
      end
      if (acc && off >= 0 && off < 4) begin
        m_sh[off] = io_data_in;
        if (m_imm) m_ac[off] = io_data_in;
        else       m_pend = 1'b1;
      end
      if (acc && off == 4 && !m_wait) m_wait = 1'b1;
      else if (ev)                    m_wait = 1'b0;
      if (acc && off == 5) m_imm = io_data_in[0];
      m_vprev = vga_v_sync;
    end
    m_ack = !io_in;
  endtask

  task automatic step(input bit r, io, input logic [15:0] a, input logic [7:0] d, input bit vs);
    reset = r; io_in = io; io_address_in = a; io_data_in = d; vga_v_sync = vs;
    model_step();
    @(posedge clk);
    #1;
    check("m_enables", en_s, {m_ac[0][7], m_ac[0][4:0]});
    check("m_scroll_x", scroll_x, {m_ac[2][1:0], m_ac[1]});
    check("m_scroll_y", scroll_y, {m_ac[2][4], m_ac[3]});
    check("m_cpuwait", cpuwait, m_wait);
    check("m_pending", pending, m_pend);
    check("m_frame_count", frame_count, m_fc);
  endtask

  initial begin
    bit         r, io, vs;
    logic [15:0] a;
    logic [7:0]  d;

    tbl.push_back(mk(1, 1, 8'h00, 8'h00, 1, 6'h3E, 10'h000, 9'h000, 0, 0, 8'd0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 0, 8'h20, 8'h81, 1, 6'h3E, 10'h000, 9'h000, 0, 1, 8'd0));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h3E, 10'h000, 9'h000, 0, 1, 8'd0));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 6'h21, 10'h000, 9'h000, 0, 0, 8'd1));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h21, 10'h000, 9'h000, 0, 0, 8'd1));
    tbl.push_back(mk(0, 0, 8'h21, 8'h34, 1, 6'h21, 10'h000, 9'h000, 0, 1, 8'd1));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h21, 10'h000, 9'h000, 0, 1, 8'd1));
    tbl.push_back(mk(0, 0, 8'h22, 8'h13, 1, 6'h21, 10'h000, 9'h000, 0, 1, 8'd1));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h21, 10'h000, 9'h000, 0, 1, 8'd1));
    tbl.push_back(mk(0, 0, 8'h23, 8'hA5, 1, 6'h21, 10'h000, 9'h000, 0, 1, 8'd1));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h21, 10'h000, 9'h000, 0, 1, 8'd1));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 6'h21, 10'h334, 9'h1A5, 0, 0, 8'd2));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h21, 10'h334, 9'h1A5, 0, 0, 8'd2));
    tbl.push_back(mk(0, 0, 8'h25, 8'h01, 1, 6'h21, 10'h334, 9'h1A5, 0, 0, 8'd2));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h21, 10'h334, 9'h1A5, 0, 0, 8'd2));
    tbl.push_back(mk(0, 0, 8'h20, 8'h00, 1, 6'h00, 10'h334, 9'h1A5, 0, 0, 8'd2));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h00, 10'h334, 9'h1A5, 0, 0, 8'd2));
    tbl.push_back(mk(0, 0, 8'h24, 8'h5A, 1, 6'h00, 10'h334, 9'h1A5, 1, 0, 8'd2));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h00, 10'h334, 9'h1A5, 1, 0, 8'd2));
    tbl.push_back(mk(0, 0, 8'h24, 8'h00, 1, 6'h00, 10'h334, 9'h1A5, 1, 0, 8'd2));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h00, 10'h334, 9'h1A5, 1, 0, 8'd2));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 6'h00, 10'h334, 9'h1A5, 0, 0, 8'd3));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h00, 10'h334, 9'h1A5, 0, 0, 8'd3));
    tbl.push_back(mk(0, 0, 8'h25, 8'h00, 1, 6'h00, 10'h334, 9'h1A5, 0, 0, 8'd3));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h00, 10'h334, 9'h1A5, 0, 0, 8'd3));
    // Write accepted on the same edge as a commit: old shadow committed, new one pending.
    tbl.push_back(mk(0, 0, 8'h21, 8'h55, 0, 6'h00, 10'h334, 9'h1A5, 0, 1, 8'd4));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h00, 10'h334, 9'h1A5, 0, 1, 8'd4));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 6'h00, 10'h355, 9'h1A5, 0, 0, 8'd5));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h00, 10'h355, 9'h1A5, 0, 0, 8'd5));
    // Reset mid-wait and mid-strobe; the held strobe must not be accepted afterwards.
    tbl.push_back(mk(0, 0, 8'h24, 8'h00, 1, 6'h00, 10'h355, 9'h1A5, 1, 0, 8'd5));
    tbl.push_back(mk(1, 0, 8'h24, 8'h00, 1, 6'h3E, 10'h000, 9'h000, 0, 0, 8'd0));
    tbl.push_back(mk(0, 0, 8'h20, 8'h00, 1, 6'h3E, 10'h000, 9'h000, 0, 0, 8'd0));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 1, 6'h3E, 10'h000, 9'h000, 0, 0, 8'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].io, {8'h00, tbl[i].addr}, tbl[i].data, tbl[i].vs);
      check($sformatf("row%0d_enables", i), en_s, tbl[i].en);
      check($sformatf("row%0d_scroll_x", i), scroll_x, tbl[i].sx);
      check($sformatf("row%0d_scroll_y", i), scroll_y, tbl[i].sy);
      check($sformatf("row%0d_cpuwait", i), cpuwait, tbl[i].w);
      check($sformatf("row%0d_pending", i), pending, tbl[i].p);
      check($sformatf("row%0d_frame_count", i), frame_count, tbl[i].fc);
    end

    // vsync held low for several cycles commits only once.
    step(0, 1, 16'h0000, 8'h00, 0);
    step(0, 1, 16'h0000, 8'h00, 0);
    step(0, 1, 16'h0000, 8'h00, 0);
    check("vsync_held_low", frame_count, 8'd1);
    step(0, 1, 16'h0000, 8'h00, 1);

    // 256 commits from zero wrap the frame counter back to zero.
    step(1, 1, 16'h0000, 8'h00, 1);
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 16'h0000, 8'h00, 0);
      step(0, 1, 16'h0000, 8'h00, 1);
    end
    check("frame_wrap", frame_count, 8'd0);

    // Random traffic around the register window, including out-of-map addresses.
    r = 0; io = 1; vs = 1; a = 16'h0000; d = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) io = ~io;
      if (io) begin
        a = {8'($urandom_range(0, 255)), 8'(8'h1E + $urandom_range(0, 9))};
        d = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 7) == 0) vs = ~vs;
      step(r, io, a, d, vs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
